// File: rtl/invol_arb.sv
// Round-robin arbiter granting one unit at a time the shared response path.
// Optional forced release on owner timeout: define INVOL_ARB_TIMEOUT_EN.
module invol_arb #(
  parameter int          NREQ           = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535,
  localparam int         IW             = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   done,
  input  logic [NREQ*33-1:0] param_data_in,
  input  logic [NREQ-1:0]   param_write_in,
  output logic [NREQ-1:0]   grant,
  output logic              up_req,
  input  logic              up_grant,
  output logic [32:0]       param_data,
  output logic              param_write,
  output logic              busy,
  output logic [IW-1:0]     cur_id,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ_UP,
    S_GRANTED,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] cur_oh;
  logic [32:0]     sel_word;
  logic            sel_wr;
  logic            done_cur;
  logic            to_hit;

  if (NREQ < 1 || NREQ > 16 || TIMEOUT_CYCLES == 32'd0) begin : g_bad_cfg
    $error("invol_arb: bad NREQ or TIMEOUT_CYCLES");
  end

  // Round-robin pick: first requester at or after last+1, wrapping
  always_comb begin
    int j;
    logic found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(last) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Owner-side views: one-hot id, its param word/strobe and its done
  always_comb begin
    cur_oh   = '0;
    sel_word = '0;
    sel_wr   = 1'b0;
    done_cur = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_id == IW'(i)) begin
        cur_oh[i] = 1'b1;
        sel_word  = param_data_in[33*i +: 33];
        sel_wr    = param_write_in[i];
        done_cur  = done[i];
      end
    end
  end

`ifdef INVOL_ARB_TIMEOUT_EN
  logic [31:0] cnt;

  assign to_hit = (state == S_GRANTED) &&
                  (cnt == TIMEOUT_CYCLES - 32'd1);

  // Owner-hold counter and sticky forced-release flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_REQ_UP) cnt <= '0;
      else if (state == S_GRANTED) cnt <= cnt + 32'd1;
      if (to_hit && !done_cur) timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      up_req      <= 1'b0;
      param_write <= 1'b0;
      param_data  <= '0;
      busy        <= 1'b0;
      cur_id      <= '0;
      last        <= IW'(NREQ - 1);
    end else begin
      grant       <= '0;
      param_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            cur_id <= win;
            up_req <= 1'b1;
            busy   <= 1'b1;
            state  <= S_REQ_UP;
          end
        end
        S_REQ_UP: begin
          if (up_grant) begin
            up_req <= 1'b0;
            grant  <= cur_oh;
            state  <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          param_write <= sel_wr;
          if (sel_wr) param_data <= sel_word;
          if (done_cur || to_hit) begin
            last  <= cur_id;
            busy  <= 1'b0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_invol_arb.sv
// Directed bench for invol_arb (NREQ=4, TIMEOUT_CYCLES=10).
// Table of per-cycle vectors plus sequences for rotation, reset, timeout.
module tb_invol_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   done = '0;
  logic [131:0] param_data_in;
  logic [3:0]   param_write_in = '0;
  logic [3:0]   grant;
  logic         up_req;
  logic         up_grant = 1'b0;
  logic [32:0]  param_data;
  logic         param_write;
  logic         busy;
  logic [1:0]   cur_id;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  localparam logic [32:0] W0 = 33'h0_000000A0;
  localparam logic [32:0] W1 = 33'h1_00000041;
  localparam logic [32:0] W2 = 33'h0_000000A2;
  localparam logic [32:0] W3 = 33'h0_00000007;

  invol_arb #(.NREQ(4), .TIMEOUT_CYCLES(32'd10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .param_data_in(param_data_in),
    .param_write_in(param_write_in),
    .grant(grant),
    .up_req(up_req),
    .up_grant(up_grant),
    .param_data(param_data),
    .param_write(param_write),
    .busy(busy),
    .cur_id(cur_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  done;
    logic        ug;
    logic [3:0]  pwi;
    logic [3:0]  g;
    logic        up;
    logic        bsy;
    logic [1:0]  cid;
    logic        pw;
    logic [32:0] pd;
  } vec_t;

  vec_t q[$];

  task automatic add(input logic [3:0] r, input logic [3:0] d,
                     input logic u, input logic [3:0] w,
                     input logic [3:0] g, input logic up,
                     input logic b, input logic [1:0] c,
                     input logic pw, input logic [32:0] pd);
    vec_t v;
    v.req = r; v.done = d; v.ug = u; v.pwi = w;
    v.g = g; v.up = up; v.bsy = b; v.cid = c;
    v.pw = pw; v.pd = pd;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; done = '0; up_grant = 1'b0; param_write_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic got);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (grant != '0) got = 1'b1;
    end
  endtask

  initial begin
    logic got;
    logic [1:0] owner;
    logic [3:0] fair_exp [5];
    param_data_in = {W3, W2, W1, W0};
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // req, done, ug, pwi | grant, up_req, busy, cur_id, pw, pd
    add(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 2, 0, 33'h0);
    add(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 2, 0, 33'h0);
    add(4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 2, 0, 33'h0);
    add(4'b0100, 4'b0000, 1, 4'b0000, 4'b0100, 0, 1, 2, 0, 33'h0);
    add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 2, 0, 33'h0);
    add(4'b0000, 4'b0000, 0, 4'b1100, 4'b0000, 0, 1, 2, 1, W2);
    add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 2, 0, W2);
    add(4'b0000, 4'b0010, 0, 4'b0000, 4'b0000, 0, 1, 2, 0, W2);
    add(4'b0000, 4'b0100, 0, 4'b0100, 4'b0000, 0, 0, 2, 1, W2);
    add(4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 2, 0, W2);
    add(4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 3, 0, W2);
    add(4'b1010, 4'b0000, 1, 4'b0000, 4'b1000, 0, 1, 3, 0, W2);
    add(4'b1010, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 3, 0, W2);
    add(4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 3, 0, W2);
    add(4'b1010, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 1, 0, W2);
    add(4'b1010, 4'b0000, 1, 4'b0000, 4'b0010, 0, 1, 1, 0, W2);
    add(4'b0010, 4'b0000, 0, 4'b1010, 4'b0000, 0, 1, 1, 1, W1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 1, 0, W1);
    add(4'b0000, 4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, W1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1, 0, W1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1, 0, W1);

    do_reset();
    #1;
    chk("reset_state",
        {grant, up_req, busy, cur_id, param_write, param_data, timeout_err},
        '0);

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      req = q[i].req; done = q[i].done;
      up_grant = q[i].ug; param_write_in = q[i].pwi;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {grant, up_req, busy, cur_id, param_write, param_data},
          {q[i].g, q[i].up, q[i].bsy, q[i].cid, q[i].pw, q[i].pd});
    end

    // Rotation with all units requesting
    do_reset();
    req = 4'b1111;
    up_grant = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(got);
      chk($sformatf("fair%0d", n), {60'h0, grant}, {60'h0, fair_exp[n]});
      owner = cur_id;
      if (n < 4) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        done = 4'b0001 << owner;
        @(negedge clk);
        done = '0;
      end
    end

    // Asynchronous reset while owner 0 is forwarding a write
    @(negedge clk);
    param_write_in = 4'b0001;
    @(posedge clk);
    #1;
    chk("pw_before_rst", {param_write, param_data}, {1'b1, W0});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        {grant, up_req, busy, cur_id, param_write, param_data, timeout_err},
        '0);
    @(negedge clk);
    param_write_in = '0;
    req = 4'b0101;
    up_grant = 1'b1;
    rst_n = 1'b1;
    wait_grant(got);
    chk("post_rst_win", {grant, cur_id}, {4'b0001, 2'd0});

    // Owner never signals done
    do_reset();
    req = 4'b1010;
    up_grant = 1'b1;
    wait_grant(got);
    chk("to_grant", {60'h0, grant}, {60'h0, 4'b0010});
    repeat (9) @(posedge clk);
    #1;
    chk("to_hold9", {busy, timeout_err}, 2'b10);
    @(posedge clk);
    #1;
`ifdef INVOL_ARB_TIMEOUT_EN
    chk("to_release", {busy, timeout_err}, 2'b01);
    wait_grant(got);
    chk("to_next", {grant, timeout_err}, {4'b1000, 1'b1});
`else
    chk("to_none", {busy, timeout_err}, 2'b10);
    repeat (20) @(posedge clk);
    #1;
    chk("to_stay", {busy, timeout_err, cur_id}, {1'b1, 1'b0, 2'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/invol_arb.md
INVOL_ARB -- requirements
Module: invol_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesting units (1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: max GRANTED cycles before forced release (32-bit, >0).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-unit involuntary-response request, level.
REQ-006 done  input  NREQ  per-unit end-of-transaction pulse.
REQ-007 param_data_in  input  NREQ*33  packed per-unit param words; unit i at [33*i+32:33*i].
REQ-008 param_write_in  input  NREQ  per-unit param write strobe.
REQ-009 grant  output  NREQ  one-hot, single-cycle grant pulse to winning unit.
REQ-010 up_req  output  1  request for the shared response path.
REQ-011 up_grant  input  1  upstream grant pulse.
REQ-012 param_data  output  33  registered forwarded param word.
REQ-013 param_write  output  1  registered forwarded write strobe.
REQ-014 busy  output  1  high in REQ_UP and GRANTED.
REQ-015 cur_id  output  max(1,clog2(NREQ))  index of the current/last owner.
REQ-016 timeout_err  output  1  sticky forced-release flag.

Function
REQ-017 FSM states: IDLE, REQ_UP, GRANTED, RELEASE; all outputs registered.
REQ-018 IDLE, req nonzero: winner = first set bit scanning from (last+1) mod NREQ upward with wrap; latch cur_id; up_req=1 next cycle; go to REQ_UP.
REQ-019 REQ_UP: up_req held high until up_grant; cycle after up_grant: up_req=0, grant[cur_id]=1 for exactly one cycle, state GRANTED.
REQ-020 Winner req dropping during REQ_UP is ignored; grant still issued.
REQ-021 up_grant outside REQ_UP is ignored.
REQ-022 GRANTED: param_write_in[cur_id] and param_data_in[cur_id] appear on param_write/param_data one cycle later; other units' writes are discarded.
REQ-023 Write asserted in the same cycle as done[cur_id] is forwarded.
REQ-024 done[cur_id] in GRANTED: last=cur_id, state RELEASE; done from other units ignored in all states.
REQ-025 RELEASE lasts one cycle; param_write=0; busy=0; then IDLE; new arbitration no earlier than the IDLE cycle.
REQ-026 param_write is 0 in IDLE, REQ_UP, RELEASE; param_data holds last value when param_write is 0.
REQ-027 Latencies: req to up_req 1 cycle; up_grant to grant 1 cycle; done to busy low 1 cycle; done to next up_req at least 2 cycles.
REQ-028 Fairness: with all req continuously high, owners rotate 0,1,...,NREQ-1,0.
REQ-029 NREQ=1: round-robin degenerates to unit 0 always; cur_id width 1.

Reset
REQ-030 rst_n low: state IDLE, grant=0, up_req=0, param_write=0, param_data=0, busy=0, cur_id=0, timeout_err=0, last=NREQ-1, asynchronously, including mid-transaction.
REQ-031 First cycle after rst_n rises behaves as IDLE; unit 0 has highest priority first.

Configuration
REQ-032 Macro INVOL_ARB_TIMEOUT_EN defined: counter cleared on GRANTED entry, increments each GRANTED cycle; on reaching TIMEOUT_CYCLES without done: last=cur_id, state RELEASE, timeout_err=1 until reset.
REQ-033 done and timeout in the same cycle: treated as done, timeout_err unchanged.
REQ-034 Macro undefined: no counter logic, timeout_err constant 0, TIMEOUT_CYCLES unused; GRANTED held until done.

Verification
REQ-035 NREQ=4, req=0b0100, up_grant 3 cycles after up_req -> up_req 1 cycle after req, grant=0b0100 one cycle after up_grant, cur_id=2.
REQ-036 All req high, each owner does done 5 cycles after grant -> grant order 0b0001,0b0010,0b0100,0b1000,0b0001.
REQ-037 Owner 1 writes 0x1_00000041 while unit 3 writes 0x0_00000007 -> param_data=0x1_00000041 one cycle later, unit 3 word never appears.
REQ-038 rst_n low in GRANTED with param_write high -> all outputs 0 immediately; after release req=0b0001 wins first.
REQ-039 INVOL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, owner never asserts done -> RELEASE after 10 GRANTED cycles, timeout_err=1, next requester granted; without macro arbiter stays GRANTED, timeout_err=0.
